// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 "valid" convolution over an IMG_W x IMG_H frame.
// Two line buffers feed a 3x3 window; a signed runtime kernel drives a 9-tap MAC.
module conv3x3_stream #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     k_we,
    input  logic [3:0]               k_addr,
    input  logic signed [DATA_W-1:0] k_data,
    input  logic                     pix_valid,
    input  logic [DATA_W-1:0]        pix_data,
    output logic                     pix_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = 2 * DATA_W + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                   state_q;
    logic                     busy_q;
    logic                     frame_done_q;
    logic                     out_valid_q;
    logic                     out_last_q;
    logic signed [ACC_W-1:0]  out_data_q;

    logic signed [DATA_W-1:0] k_q   [9];
    logic signed [DATA_W-1:0] k_d   [9];
    logic [DATA_W-1:0]        lb0_q [IMG_W];
    logic [DATA_W-1:0]        lb1_q [IMG_W];
    logic [DATA_W-1:0]        win_q [3][3];
    logic [DATA_W-1:0]        win_d [3][3];
    logic [CW-1:0]            col_q;
    logic [CW-1:0]            col_d;
    logic [RW-1:0]            row_q;
    logic [RW-1:0]            row_d;
    logic signed [PW-1:0]     prod  [9];
    logic signed [ACC_W-1:0]  acc;

    logic accept;
    logic produce;
    logic col_end;
    logic row_end;
    logic last_hs;

    assign pix_ready = !out_valid_q || out_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_end   = (col_q == CW'(IMG_W - 1));
    assign row_end   = (row_q == RW'(IMG_H - 1));
    assign produce   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_hs   = out_valid_q && out_ready && out_last_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // A write landing with the first pixel of a frame must already apply.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            k_d[i] = k_q[i];
            if (k_we && !busy_q && (k_addr == 4'(i)))
                k_d[i] = k_data;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb1_q[col_q];
        win_d[1][2] = lb0_q[col_q];
        win_d[2][2] = pix_data;
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            prod[i] = PW'($signed({1'b0, win_d[i / 3][i % 3]})) * PW'(k_d[i]);
            acc     = acc + ACC_W'(prod[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
            for (int i = 0; i < 9; i++)
                k_q[i] <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            for (int i = 0; i < 9; i++)
                k_q[i] <= k_d[i];
            if (accept) begin
                col_q        <= col_d;
                row_q        <= row_d;
                lb1_q[col_q] <= lb0_q[col_q];
                lb0_q[col_q] <= pix_data;
                win_q        <= win_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (produce) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc;
            out_last_q  <= row_end && col_end;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    // Back-to-back frames: a new accept on the final handshake keeps RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_hs;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_hs && !accept) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: directed frames with a queue scoreboard and a negedge
// monitor that pops and compares every result handshake.
module tb_conv3x3_stream;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               k_we;
    logic [3:0]         k_addr;
    logic signed [7:0]  k_data;
    logic               pix_valid;
    logic [7:0]         pix_data;
    logic               pix_ready;
    logic               out_valid;
    logic signed [19:0] out_data;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               frame_done;

    conv3x3_stream #(
        .IMG_W(8), .IMG_H(8), .DATA_W(8), .ACC_W(20)
    ) dut (
        .clk(clk), .reset(rst_n),
        .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t              exp_q[$];
    logic [7:0]        img[64];
    int                expv[8][8];
    logic signed [7:0] kset[9];
    int                acc_cnt = 0;
    int                n_chk = 0;
    int                n_pass = 0;
    bit                fd_pend = 0;

    task automatic check(input bit ok, input string name,
                         input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(posedge clk)
        if (pix_valid && pix_ready) acc_cnt <= acc_cnt + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            fd_pend = 0;
        end else begin
            if (fd_pend || frame_done)
                check(frame_done == fd_pend, "frame_done", frame_done, fd_pend);
            fd_pend = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_result", out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(int'(out_data) == e.data, "out_data", out_data, e.data);
                    check(out_last == e.last, "out_last", out_last, e.last);
                end
                fd_pend = out_last;
            end
        end
    end

    task automatic send_pix(input logic [7:0] p);
        int prev;
        int t;
        prev = acc_cnt;
        t = 0;
        pix_valid = 1'b1;
        pix_data  = p;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (acc_cnt == prev && t < 300);
        if (acc_cnt == prev) check(0, "accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int npix, input bit keep);
        exp_t e;
        for (int i = 0; i < npix; i++) begin
            if (i / 8 >= 2 && i % 8 >= 2) begin
                e.data = expv[i / 8][i % 8];
                e.last = (i == 63);
                exp_q.push_back(e);
            end
            send_pix(img[i]);
        end
        if (!keep) pix_valid = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int t;
        t = 0;
        while (acc_cnt < target && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(acc_cnt >= target, "wait_accepts", acc_cnt, target);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(exp_q.size() == 0, "drain_missing", exp_q.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kwrite(input int a, input logic signed [7:0] d);
        k_we   = 1'b1;
        k_addr = 4'(a);
        k_data = d;
        @(posedge clk);
        #1;
        k_we = 1'b0;
    endtask

    task automatic load_k();
        for (int i = 0; i < 9; i++) kwrite(i, kset[i]);
    endtask

    task automatic set_identity_ramp();
        for (int i = 0; i < 9; i++) kset[i] = 8'sd0;
        kset[4] = 8'sd1;
        for (int i = 0; i < 64; i++) img[i] = 8'(i);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                expv[r][c] = (r - 1) * 8 + (c - 1);
    endtask

    function automatic void model();
        int s;
        for (int r = 2; r < 8; r++)
            for (int c = 2; c < 8; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += int'(img[(r - 2 + i) * 8 + c - 2 + j]) * int'(kset[i * 3 + j]);
                expv[r][c] = s;
            end
    endfunction

    initial begin
        int base;
        int hold;
        rst_n = 1'b1;
        pix_valid = 1'b0;
        pix_data = '0;
        k_we = 1'b0;
        k_addr = '0;
        k_data = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(out_data == '0, "rst_out_data", out_data, 0);
        check(out_last == 1'b0, "rst_out_last", out_last, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
        check(pix_ready == 1'b1, "rst_pix_ready", pix_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // identity kernel over a ramp image
        set_identity_ramp();
        load_k();
        send_frame(64, 0);
        drain();
        check(busy == 1'b0, "idle_after_frame", busy, 0);

        // kernel write while busy is ignored, honoured once idle
        base = acc_cnt;
        fork
            send_frame(64, 0);
            begin
                wait_acc(base + 5);
                check(busy == 1'b1, "busy_mid_frame", busy, 1);
                kwrite(4, 8'sd5);
            end
        join
        drain();
        kwrite(4, 8'sd5);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                expv[r][c] = 5 * ((r - 1) * 8 + (c - 1));
        send_frame(64, 0);
        drain();

        // all-ones kernel, saturated image
        for (int i = 0; i < 9; i++) kset[i] = 8'sd1;
        load_k();
        for (int i = 0; i < 64; i++) img[i] = 8'd255;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) expv[r][c] = 2295;
        send_frame(64, 0);
        drain();

        // most negative kernel: bottom of the result range
        for (int i = 0; i < 9; i++) kset[i] = -8'sd128;
        load_k();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) expv[r][c] = -293760;
        send_frame(64, 0);
        drain();

        // mixed-sign kernel with a downstream stall mid-frame
        kset[0] = 8'sd1;  kset[1] = -8'sd2; kset[2] = 8'sd3;
        kset[3] = -8'sd4; kset[4] = 8'sd5;  kset[5] = -8'sd6;
        kset[6] = 8'sd7;  kset[7] = -8'sd8; kset[8] = 8'sd9;
        load_k();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r * 8 + c] = 8'((r * 37 + c * 11 + 5) & 255);
        model();
        base = acc_cnt;
        fork
            send_frame(64, 0);
            begin
                wait_acc(base + 20);
                out_ready = 1'b0;
                @(negedge clk);
                hold = out_data;
                check(out_valid == 1'b1, "stall_out_valid", out_valid, 1);
                repeat (5) begin
                    check(pix_ready == 1'b0, "stall_pix_ready", pix_ready, 0);
                    check(int'(out_data) == hold, "stall_out_data", out_data, hold);
                    @(negedge clk);
                end
                check(acc_cnt == base + 20, "stall_no_accept", acc_cnt, base + 20);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // reset in the middle of a frame
        set_identity_ramp();
        load_k();
        send_frame(30, 0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
        check(busy == 1'b0, "midrst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        load_k();
        send_frame(64, 0);
        drain();

        // two frames back to back with pix_valid held high
        send_frame(64, 1);
        send_frame(64, 0);
        drain();
        check(busy == 1'b0, "idle_after_b2b", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
